// File: rtl/full_adder_unit_pkg.sv
// Shared constants for the registered ripple-carry adder.
package full_adder_unit_pkg;

    localparam int unsigned MAX_WIDTH = 64;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder cell; the leaf of the ripple chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder_unit.sv
// Registered full adder: ripple-carry chain of 1-bit cells feeding one result register.
module full_adder_unit
    import full_adder_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("full_adder_unit: WIDTH out of range");
    end

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             out_valid_q;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum_d[i]),
            .co (carry[i+1])
        );
    end

    // Result holds its last value while idle; only out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= carry[WIDTH];
            end
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder_unit.sv
// Self-checking bench: WIDTH=1 and WIDTH=8 instances against an arithmetic reference model.
module tb_full_adder_unit;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       iv1, a1, b1, c1;
    logic       s1, co1, ov1;
    logic       iv8, c8;
    logic [7:0] a8, b8;
    logic [7:0] s8;
    logic       co8, ov8;

    // Reference model state
    logic       es1, ec1, ev1;
    logic [7:0] es8;
    logic       ec8, ev8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    full_adder_unit #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv1),
        .a         (a1),
        .b         (b1),
        .cin       (c1),
        .sum       (s1),
        .cout      (co1),
        .out_valid (ov1)
    );

    full_adder_unit #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv8),
        .a         (a8),
        .b         (b8),
        .cin       (c8),
        .sum       (s8),
        .cout      (co8),
        .out_valid (ov8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".sum1"}, 64'(s1), 64'(es1));
        check({tag, ".cout1"}, 64'(co1), 64'(ec1));
        check({tag, ".valid1"}, 64'(ov1), 64'(ev1));
        check({tag, ".sum8"}, 64'(s8), 64'(es8));
        check({tag, ".cout8"}, 64'(co8), 64'(ec8));
        check({tag, ".valid8"}, 64'(ov8), 64'(ev8));
    endtask

    task automatic model_reset();
        es1 = 1'b0; ec1 = 1'b0; ev1 = 1'b0;
        es8 = 8'h00; ec8 = 1'b0; ev8 = 1'b0;
    endtask

    // One clock edge: advance the model from the inputs seen at the edge, then check.
    task automatic tick(input string tag);
        logic [9:0] t;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (iv1) begin
                t   = 10'(a1) + 10'(b1) + 10'(c1);
                es1 = t[0];
                ec1 = t[1];
            end
            ev1 = iv1;
            if (iv8) begin
                t   = 10'(a8) + 10'(b8) + 10'(c8);
                es8 = t[7:0];
                ec8 = t[8];
            end
            ev8 = iv8;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [2:0] v;
        rst_n = 1'b0;
        iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        model_reset();

        // Reset held with operands present and clock running
        #1;
        check_all("reset_async");
        tick("reset_hold0");
        tick("reset_hold1");

        rst_n = 1'b1;
        tick("reset_release");

        // Exhaustive 1-bit truth table, back-to-back
        for (int i = 0; i < 8; i++) begin
            v  = 3'(i);
            a1 = v[2]; b1 = v[1]; c1 = v[0];
            tick($sformatf("truth%0d", i));
        end

        // Reset between edges clears outputs immediately
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset_mid");
        #1;
        rst_n = 1'b1;

        // Hold: capture 1+0+1, then idle with changed operands
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
        tick("hold_capture");
        iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        for (int i = 0; i < 3; i++) tick($sformatf("hold_idle%0d", i));

        // Wide carry boundaries
        iv8 = 1'b1;
        a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; tick("w8_ff_00_1");
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; tick("w8_ff_ff_1");
        a8 = 8'h5A; b8 = 8'h25; c8 = 1'b0; tick("w8_5a_25_0");
        a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; tick("w8_zero");

        // Random back-to-back throughput
        for (int i = 0; i < 100; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            c8 = 1'($urandom_range(0, 1));
            tick($sformatf("rand%0d", i));
        end

        // Idle after stream: result holds, valid drops
        iv8 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        tick("w8_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
